serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b, LSB-first, one bit per clock.
- Uses a single full-subtractor cell and a registered borrow flip-flop.
- Sits beside the combinational adder datapath as the area-cheap inverse operation.
- Handshake: start/busy/done. Operands are captured on start; the result is held until the next accepted start.

---
 rtl/serial_subtractor.sv | 77 +++++++
 tb/tb_serial_subtractor.sv | 135 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Define SIGNED_OVF_EN to add the signed-overflow output.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SIGNED_OVF_EN
  ,
  output logic             overflow
`endif
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_diff;
  logic [CW-1:0] r_cnt;
  logic r_bor, r_borrow_out;
  logic w_ai, w_bi, w_d, w_bor_next, w_last, w_accept;
  assign w_ai       = r_a[0];
  assign w_bi       = r_b[0];
  assign w_d        = w_ai ^ w_bi ^ r_bor;
  assign w_bor_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bor);
  assign w_last     = r_cnt == CW'(WIDTH - 1);
  assign w_accept   = (r_state == IDLE) && start;
  assign busy       = r_state != IDLE;
  assign done       = r_state == DONE;
  assign diff       = r_diff;
  assign borrow_out = r_borrow_out;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)  ? (start ? SHIFT : IDLE) :
             (r_state == SHIFT) ? (w_last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a          <= '0;
      r_b          <= '0;
      r_diff       <= '0;
      r_cnt        <= '0;
      r_bor        <= 1'b0;
      r_borrow_out <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_bor <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a    <= r_a >> 1;
      r_b    <= r_b >> 1;
      r_bor  <= w_bor_next;
      r_diff <= {w_d, r_diff[WIDTH-1:1]};
      r_cnt  <= r_cnt + 1'b1;
      if (w_last) r_borrow_out <= w_bor_next;
    end
  end
`ifdef SIGNED_OVF_EN
  // On the last bit the shift registers expose the captured operand MSBs and w_d is the result MSB.
  logic r_ovf;
  assign overflow = r_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_ovf <= 1'b0;
    else if (r_state == SHIFT && w_last) r_ovf <= (w_ai != w_bi) && (w_d != w_ai);
  end
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of the serial subtractor handshake, latency and results.
module tb_serial_subtractor;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] a = '0, b = '0, diff;
  logic busy, done, borrow_out;
  int errors = 0, checks = 0;
`ifdef SIGNED_OVF_EN
  logic overflow;
`endif
  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SIGNED_OVF_EN
    , .overflow(overflow)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ed,
                        input logic eb, input logic eo);
    int n;
    a = ia; b = ib; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, 8);
    chk("diff", diff, ed);
    chk("borrow", borrow_out, eb);
`ifdef SIGNED_OVF_EN
    chk("overflow", overflow, eo);
`endif
    tick();
    chk("idle_after_done", {busy, done}, 0);
  endtask
  initial begin
    int n, pulses, last_t;
    logic [7:0] pa[4] = '{8'h5A, 8'h00, 8'h80, 8'h12};
    logic [7:0] pb[4] = '{8'h23, 8'h01, 8'h7F, 8'h34};
    logic [7:0] pd[4] = '{8'h37, 8'hFF, 8'h01, 8'hDE};
    logic       pbo[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    #12;
    chk("reset_outputs", {busy, done, diff, borrow_out}, 0);
    rst = 1'b0;
    tick();
    // Basic op with busy/done timing traced edge by edge
    a = 8'h5A; b = 8'h23; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    for (int i = 1; i <= 9; i++) begin
      if (busy) n++;
      if (i < 9 && done) chk("early_done", done, 0);
      tick();
    end
    chk("busy_cycles", n, 9);
    chk("done_pulse", {busy, done}, 0);
    chk("diff_5A_23", diff, 8'h37);
    chk("borrow_5A_23", borrow_out, 0);
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    repeat (3) tick();
    chk("hold_diff", diff, 8'hFF);
    chk("hold_borrow", borrow_out, 1);
    run_op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    // start pulse while busy must not disturb the running op
    a = 8'h10; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    a = 8'hAA; b = 8'h55; start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        pulses++;
        chk("ignore_diff", diff, 8'h0F);
        chk("ignore_borrow", borrow_out, 0);
      end
      tick();
    end
    chk("ignore_pulses", pulses, 1);
    // start held high: back-to-back ops every WIDTH+2 cycles
    a = pa[0]; b = pb[0]; start = 1'b1;
    pulses = 0; last_t = 0;
    for (int t = 0; t < 60 && pulses < 4; t++) begin
      tick();
      if (done) begin
        chk("b2b_diff", diff, pd[pulses]);
        chk("b2b_borrow", borrow_out, pbo[pulses]);
        if (pulses > 0) chk("b2b_spacing", t - last_t, 10);
        last_t = t;
        pulses++;
        if (pulses < 4) begin a = pa[pulses]; b = pb[pulses]; end
      end
    end
    chk("b2b_pulses", pulses, 4);
    start = 1'b0;
    repeat (3) tick();
    // Asynchronous reset in the middle of SHIFT
    a = 8'h5A; b = 8'h23; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1 chk("async_reset", {busy, done, diff, borrow_out}, 0);
    tick();
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    chk("no_done_after_abort", pulses, 0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
